// File: rtl/silife_pkg.sv
// Shared definitions for the silife cell array: rule masks, reset rule and state sizing.
package silife_pkg;

  localparam int NBR_W = 8;
  localparam int CNT_W = 4;

  typedef logic [8:0] rule_mask_t;

  // B3/S23: classic Conway rule loaded on reset
  localparam rule_mask_t CONWAY_BIRTH   = 9'h008;
  localparam rule_mask_t CONWAY_SURVIVE = 9'h00C;

  function automatic int state_width(input int states);
    return (states <= 2) ? 1 : $clog2(states);
  endfunction

endpackage

// File: rtl/silife_neighbor_count.sv
// Popcount of the eight neighbour alive flags; 0..8 fits in four bits without wrap.
module silife_neighbor_count
  import silife_pkg::*;
(
  input  logic [NBR_W-1:0] neighbors,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NBR_W; i++)
      count = count + {{(CNT_W-1){1'b0}}, neighbors[i]};
  end

endmodule

// File: rtl/silife_gen_cell.sv
// One Life/Generations cell: loadable rule, multi-state decay and a saturating age counter.
module silife_gen_cell
  import silife_pkg::*;
#(
  parameter int STATES    = 2,
  parameter int AGE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          revive,
  input  logic                          kill,
  input  logic [NBR_W-1:0]              neighbors,
  input  logic [8:0]                    rule_birth,
  input  logic [8:0]                    rule_survive,
  input  logic                          rule_load,
  output logic                          out,
  output logic [state_width(STATES)-1:0] state,
  output logic [AGE_WIDTH-1:0]          age
);

  localparam int SW = state_width(STATES);
  localparam logic [SW-1:0] DEAD   = '0;
  localparam logic [SW-1:0] ALIVE  = SW'(1);
  localparam logic [SW-1:0] DYING0 = SW'(2);
  localparam logic [SW-1:0] LAST   = SW'(STATES - 1);

  rule_mask_t           act_birth, act_survive;
  logic [CNT_W-1:0]     count;
  logic [SW-1:0]        nxt_state;
  logic [AGE_WIDTH-1:0] nxt_age;
  logic                 gen_step;

  silife_neighbor_count u_count (
    .neighbors (neighbors),
    .count     (count)
  );

  assign gen_step = enable && !kill && !revive;

  always_comb begin
    nxt_state = state;
    if (kill)
      nxt_state = DEAD;
    else if (revive)
      nxt_state = ALIVE;
    else if (enable) begin
      if (state == DEAD)
        nxt_state = act_birth[count] ? ALIVE : DEAD;
      else if (state == ALIVE)
        nxt_state = act_survive[count] ? ALIVE : ((STATES == 2) ? DEAD : DYING0);
      else
        nxt_state = (state == LAST) ? DEAD : state + SW'(1);
    end
  end

  // Age only runs while the cell stays alive across a generation step
  always_comb begin
    nxt_age = age;
    if (nxt_state != ALIVE || state != ALIVE)
      nxt_age = '0;
    else if (gen_step && age != '1)
      nxt_age = age + AGE_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DEAD;
      age         <= '0;
      act_birth   <= CONWAY_BIRTH;
      act_survive <= CONWAY_SURVIVE;
    end else begin
      state <= nxt_state;
      age   <= nxt_age;
      if (rule_load) begin
        act_birth   <= rule_birth;
        act_survive <= rule_survive;
      end
    end
  end

  assign out = (state == ALIVE);

endmodule

// File: doc/silife_gen_cell.md
SILIFE_GEN_CELL -- requirements
Module: silife_gen_cell

Interface
REQ-001 Parameter STATES, default 2, meaning total cell states (2 = classic Life; 3..16 = Generations-style decay); legal range 2..16.
REQ-002 Parameter AGE_WIDTH, default 8, meaning width of the saturating age counter; legal range 1..16.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  advance one generation this cycle.
REQ-006 Port revive  input  1  force cell to state 1 (alive).
REQ-007 Port kill  input  1  force cell to state 0 (dead).
REQ-008 Port neighbors  input  8  alive flags {nw,n,ne,e,se,s,sw,w}.
REQ-009 Port rule_birth  input  9  staged birth mask; bit k = birth when k neighbours are alive.
REQ-010 Port rule_survive  input  9  staged survive mask; bit k = survive when k neighbours are alive.
REQ-011 Port rule_load  input  1  latch staged masks into active rule registers.
REQ-012 Port out  output  1  alive flag (state == 1), fed to neighbours.
REQ-013 Port state  output  $clog2(STATES)  full cell state.
REQ-014 Port age  output  AGE_WIDTH  generations survived since last birth or revive.

Function
REQ-015 Neighbour count SHALL be 4 bits wide, range 0..8, with no overflow at 8.
REQ-016 State encoding SHALL be: 0 dead; 1 alive; 2..STATES-1 dying.
REQ-017 On enable, state 0 SHALL go to 1 if active_birth[count], else stay 0.
REQ-018 On enable, state 1 SHALL stay 1 if active_survive[count], else go to 2, or to 0 when STATES==2.
REQ-019 On enable, state k>=2 SHALL go to k+1 if k<STATES-1, else 0; neighbours are ignored.
REQ-020 Update priority SHALL be kill > revive > enable > hold; kill and revive together SHALL yield state 0.
REQ-021 A new state SHALL be visible on out/state the cycle after the sampling edge (latency 1).
REQ-022 Age SHALL clear to 0 on any entry into state 1 from another state, including by revive.
REQ-023 Age SHALL clear to 0 on leaving state 1.
REQ-024 Age SHALL increment by 1 on each enable that keeps the cell in state 1, and saturate at all-ones.
REQ-025 Revive of a cell already in state 1 SHALL leave age unchanged.
REQ-026 On rule_load, active masks SHALL take rule_birth/rule_survive at that edge; the new rule SHALL apply from the next edge.
REQ-027 A generation computed in the same cycle as rule_load SHALL use the old rule.
REQ-028 Masks SHALL be ignored when rule_load is low.

Reset
REQ-029 Reset SHALL asynchronously force state=0, out=0 and age=0.
REQ-030 Reset SHALL asynchronously force the active rule to B3/S23 (birth 9'h008, survive 9'h00C).
REQ-031 Reset asserted mid-generation SHALL override all other inputs.
REQ-032 The first enable after reset deassertion SHALL use the reset rule.

Structure
REQ-033 Shared package silife_pkg SHALL hold: rule_mask_t (9-bit), CONWAY_BIRTH and CONWAY_SURVIVE constants, and a state-width function of STATES.
REQ-034 The neighbour popcount SHALL be a sub-module, silife_neighbor_count (8-bit in, 4-bit out, combinational).
REQ-035 The rule registers, the state register and the age counter SHALL live in silife_gen_cell.

Verification
REQ-036 Reset, then 3 neighbours, enable -> state 0->1, out=1, age=0; with 2 neighbours, 5 enables -> age=5.
REQ-037 All 8 neighbours alive, rule_load with birth=9'h100, enable -> cell born (checks count=8, no wrap).
REQ-038 STATES=4, alive cell, 0 neighbours, enables -> states 1,2,3,0; during the 2->3 step birth conditions present -> ignored.
REQ-039 kill+revive+enable in the same cycle -> state 0; revive alone on alive cell -> age unchanged.
REQ-040 rule_load B36/S23 with enable in the same cycle and 6 neighbours -> no birth; next enable -> birth.
REQ-041 AGE_WIDTH=2, surviving cell, 6 enables -> age 1,2,3,3,3,3; async reset mid-cycle -> state=0, age=0 immediately.
